// File: rtl/apb_master.sv
// apb_master: APB requester turning single host commands into SETUP/ACCESS transfers.
// Optional ACCESS watchdog is compiled in with APB_MASTER_TIMEOUT_EN.
module apb_master #(
    parameter int SEL_WIDTH      = 3,
    parameter int ADDR_WIDTH     = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int SW = (SEL_WIDTH > 1) ? $clog2(SEL_WIDTH) : 1
) (
    input  logic                  i_PCLK,
    input  logic                  i_PRESETn,
    input  logic                  i_req,
    input  logic                  i_write,
    input  logic [SW-1:0]         i_sel,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_ready,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [3:0]            o_err,
    output logic                  o_timeout,
    output logic [SEL_WIDTH-1:0]  o_PSEL,
    output logic                  o_PENABLE,
    output logic                  o_PWRITE,
    output logic [ADDR_WIDTH-1:0] o_PADDR,
    output logic [DATA_WIDTH-1:0] o_PWDATA,
    input  logic                  i_PREADY,
    input  logic [DATA_WIDTH-1:0] i_PRDATA,
    input  logic [3:0]            i_PSLVERR
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                state, state_n;
    logic [SEL_WIDTH-1:0]  psel_n;
    logic                  penable_n, pwrite_n, done_n, expire;
    logic [ADDR_WIDTH-1:0] paddr_n;
    logic [DATA_WIDTH-1:0] pwdata_n, rdata_n;
    logic [3:0]            err_n;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    assign o_ready = (state == IDLE);

    // The APB output registers double as the latched command while busy.
    always_comb begin
        state_n   = state;
        psel_n    = o_PSEL;
        penable_n = o_PENABLE;
        pwrite_n  = o_PWRITE;
        paddr_n   = o_PADDR;
        pwdata_n  = o_PWDATA;
        done_n    = 1'b0;
        rdata_n   = o_rdata;
        err_n     = o_err;
        case (state)
            IDLE: if (i_req) begin
                if (int'(i_sel) >= SEL_WIDTH) begin
                    done_n = 1'b1;
                    err_n  = 4'hF;
                end else begin
                    state_n  = SETUP;
                    psel_n   = SEL_WIDTH'(1) << i_sel;
                    pwrite_n = i_write;
                    paddr_n  = i_addr;
                    pwdata_n = i_write ? i_wdata : '0;
                end
            end
            SETUP: begin
                state_n   = ACCESS;
                penable_n = 1'b1;
            end
            default: if (i_PREADY || expire) begin
                state_n   = IDLE;
                psel_n    = '0;
                penable_n = 1'b0;
                pwrite_n  = 1'b0;
                paddr_n   = '0;
                pwdata_n  = '0;
                done_n    = 1'b1;
                err_n     = i_PREADY ? i_PSLVERR : 4'hE;
                rdata_n   = (i_PREADY && !o_PWRITE) ? i_PRDATA : o_rdata;
            end
        endcase
    end

    always_ff @(posedge i_PCLK) begin
        if (!i_PRESETn) begin
            state     <= IDLE;
            o_PSEL    <= '0;
            o_PENABLE <= 1'b0;
            o_PWRITE  <= 1'b0;
            o_PADDR   <= '0;
            o_PWDATA  <= '0;
            o_done    <= 1'b0;
            o_rdata   <= '0;
            o_err     <= '0;
        end else begin
            state     <= state_n;
            o_PSEL    <= psel_n;
            o_PENABLE <= penable_n;
            o_PWRITE  <= pwrite_n;
            o_PADDR   <= paddr_n;
            o_PWDATA  <= pwdata_n;
            o_done    <= done_n;
            o_rdata   <= rdata_n;
            o_err     <= err_n;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt;

    // cnt holds the number of wait cycles already spent in ACCESS.
    assign expire = (state == ACCESS) && !i_PREADY && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_PCLK) begin
        if (!i_PRESETn) begin
            cnt       <= '0;
            o_timeout <= 1'b0;
        end else begin
            cnt <= (state == ACCESS) ? cnt + 1'b1 : '0;
            if (done_n)
                o_timeout <= expire;
        end
    end
`else
    assign expire    = 1'b0;
    assign o_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized scoreboard bench for apb_master with a behavioural APB slave.
module tb_apb_master;
    localparam int TO = 16;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] rdata;
        logic [3:0] err;
        logic       tmo;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0, rstn = 1'b0, req = 1'b0, wr = 1'b0;
    logic [1:0] sel = '0, addr = '0;
    logic [7:0] wdata = '0, prdata = '0, rdata, pwdata;
    logic       ready_in = 1'b0, ready, done, tmo, penable, pwrite;
    logic [3:0] pslverr = '0, err;
    logic [2:0] psel;
    logic [1:0] paddr;

    exp_t       q[$];
    int         checks = 0, errors = 0, cyc = 0, wcnt = 0;
    logic [7:0] model_rdata = '0;
    logic [2:0] exp_psel = '0;
    logic       exp_wr = 1'b0;
    logic [1:0] exp_addr = '0;
    logic [7:0] exp_wdata = '0;
    int         cur_waits = 0;
    logic [7:0] cur_prdata = '0;
    logic [3:0] cur_err = '0;

    apb_master #(.SEL_WIDTH(3), .ADDR_WIDTH(2), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
        .i_PCLK(clk), .i_PRESETn(rstn), .i_req(req), .i_write(wr), .i_sel(sel),
        .i_addr(addr), .i_wdata(wdata), .o_ready(ready), .o_done(done), .o_rdata(rdata),
        .o_err(err), .o_timeout(tmo), .o_PSEL(psel), .o_PENABLE(penable), .o_PWRITE(pwrite),
        .o_PADDR(paddr), .o_PWDATA(pwdata), .i_PREADY(ready_in), .i_PRDATA(prdata),
        .i_PSLVERR(pslverr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic set_bus(input bit w, input logic [1:0] s, input logic [1:0] a, input logic [7:0] d);
        req = 1'b1; wr = w; sel = s; addr = a; wdata = d;
        exp_psel = 3'(1 << s); exp_wr = w; exp_addr = a; exp_wdata = w ? d : 8'h00;
    endtask

    // Issue one command at a negedge with IDLE, queue its outcome, return at the done negedge.
    task automatic issue(input bit w, input logic [1:0] s, input logic [1:0] a, input logic [7:0] d,
                         input int waits, input logic [7:0] rd, input logic [3:0] se);
        exp_t e;
        set_bus(w, s, a, d);
        cur_waits = waits; cur_prdata = rd; cur_err = se;
        if (s >= 2'd3)
            e = '{model_rdata, 4'hF, 1'b0, cyc + 1};
        else if (TMO_EN && waits >= TO)
            e = '{model_rdata, 4'hE, 1'b1, cyc + 2 + TO};
        else begin
            if (!w) model_rdata = rd;
            e = '{model_rdata, se, 1'b0, cyc + 3 + waits};
        end
        q.push_back(e);
        @(negedge clk);
        req = 1'b0;
        for (int k = 0; !ready && k < 100; k++) begin
            req = 1'($urandom); wr = 1'($urandom); sel = 2'($urandom);
            addr = 2'($urandom); wdata = 8'($urandom);
            @(negedge clk);
        end
        req = 1'b0;
        check("ready_return", ready, 1);
    endtask

    // APB slave: holds PREADY low for cur_waits ACCESS cycles and checks bus stability.
    initial forever begin
        @(negedge clk);
        if (ready)
            check("idle_bus", {psel, penable, pwrite, paddr, pwdata}, 0);
        else
            check("busy_bus", {psel, pwrite, paddr, pwdata}, {exp_psel, exp_wr, exp_addr, exp_wdata});
        if (penable) begin
            ready_in = (wcnt == cur_waits);
            prdata   = ready_in ? cur_prdata : 8'($urandom);
            pslverr  = ready_in ? cur_err : 4'($urandom);
            wcnt++;
        end else begin
            wcnt     = 0;
            ready_in = 1'($urandom);
            prdata   = 8'($urandom);
            pslverr  = 4'($urandom);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (q.size() == 0)
                    check("spurious_done", done, 0);
                else begin
                    e = q.pop_front();
                    check("rdata", rdata, e.rdata);
                    check("err", err, e.err);
                    check("timeout", tmo, e.tmo);
                    check("done_cycle", cyc, e.cyc);
                    check("ready_on_done", ready, 1);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, expected finish by 1ms");
        $fatal(1);
    end

    initial begin
        req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_ready", ready, 1);
            check("rst_done", done, 0);
            check("rst_state", {rdata, err, tmo}, 0);
        end
        rstn = 1'b1;
        req  = 1'b0;
        @(negedge clk);
        issue(1'b1, 2'd0, 2'b01, 8'h1A, 0, 8'h00, 4'h0);
        issue(1'b0, 2'd1, 2'b00, 8'h00, 2, 8'h34, 4'h2);
        issue(1'b1, 2'd3, 2'b10, 8'h99, 0, 8'h00, 4'h0);
        issue(1'b0, 2'd2, 2'b11, 8'h00, 0, 8'h5A, 4'h7);
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) @(negedge clk);
            issue(1'($urandom), 2'($urandom_range(0, 3)), 2'($urandom), 8'($urandom),
                  int'($urandom_range(0, 5)), 8'($urandom), 4'($urandom));
        end
        issue(1'b0, 2'd2, 2'b11, 8'h00, TO + 4, 8'h5C, 4'h3);
        set_bus(1'b1, 2'd2, 2'b10, 8'h77);
        cur_waits = 50;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("pre_rst_access", penable, 1);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_rdata = '0;
        check("mid_rst_ready", ready, 1);
        check("mid_rst_done", done, 0);
        check("mid_rst_state", {rdata, err, tmo}, 0);
        issue(1'b0, 2'd0, 2'b11, 8'h00, 1, 8'hC3, 4'h0);
        for (int k = 0; q.size() > 0 && k < 50; k++) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
